flush_ctrl: RTL and testbench
=============================

# flush_ctrl

Parametrised pipeline flush and redirect controller for the out-of-order core. It arbitrates any number of branch-resolution ports against the commit-stage exception request, selects the oldest flush cause by ROB age, and issues a one-cycle registered flush pulse plus a redirect PC. It then holds the front end stalled for a configurable recovery window, during which only strictly older causes may re-trigger a flush. It sits between the execute/commit stages and the IF, IS, EX, ROB, CP0 and register-status blocks.

## Interface
- BRANCH_PORTS, 2: number of branch-resolution channels (>=1).
- ROB_IDX_WIDTH, 6: ROB index width; ROB depth is 2^ROB_IDX_WIDTH.
- ADDR_WIDTH, 32: PC width.
- RECOVER_CYCLES, 2: stall cycles after the flush pulse (0..15).
- clk  in  1  clock; one clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- except_valid  in  1  commit-stage exception request.
- except_vector  in  ADDR_WIDTH  handler PC.
- except_rob_idx  in  ROB_IDX_WIDTH  ROB index of the excepting instruction.
- br_valid  in  BRANCH_PORTS  per-port resolution valid.
- br_mispredict  in  BRANCH_PORTS  per-port mispredict flag.
- br_rob_idx  in  BRANCH_PORTS*ROB_IDX_WIDTH  per-port ROB index; port p occupies bits [p*W +: W].
- br_target  in  BRANCH_PORTS*ADDR_WIDTH  per-port correct target.
- rob_head_idx  in  ROB_IDX_WIDTH  current ROB head, used for age computation.
- flush_if, flush_is, flush_ex, flush_rob, flush_regstat  out  1  each  flush pulses.
- flush_cp0  out  1  flush pulse; asserted only for exception-caused flushes.
- redirect_valid  out  1  redirect strobe, coincident with the flush pulse.
- redirect_pc  out  ADDR_WIDTH  redirect target.
- stall_frontend  out  1  high during FLUSH and RECOVER.
- busy  out  1  state != IDLE.

## Operation
- Age: age(x) = (x - rob_head_idx) mod 2^ROB_IDX_WIDTH, computed at ROB_IDX_WIDTH bits with wrap. A smaller age is older.
- Candidates:
  - the exception, if except_valid;
  - each port p with br_valid[p] & br_mispredict[p].
- Selection:
  - An exception always beats a branch.
  - Among branches, the smallest age wins.
  - On equal age, the lowest port number wins.
- Registered state: fsm, recover counter (4 bits), pending_idx, pending_is_exc.
- States:
  - IDLE: any candidate is accepted.
  - FLUSH: lasts exactly one cycle. All flush outputs and redirect_valid are high.
  - RECOVER: the counter loads RECOVER_CYCLES and decrements each cycle. The state returns to IDLE when the counter reaches 1 while in RECOVER. With RECOVER_CYCLES=0, FLUSH goes directly to IDLE.
- Acceptance in FLUSH/RECOVER:
  - An exception is always accepted.
  - A branch is accepted only if age(br_rob_idx) < age(pending_idx), using the current head.
  - All other requests are stale and dropped silently.
- On accept (any state): latch the winner's idx, PC and type, go to FLUSH next cycle, and restart the recovery window.

## Timing
- Reset values:
  - fsm=IDLE, counter=0, pending_idx=0, pending_is_exc=0.
  - All flush_* outputs=0, redirect_valid=0, redirect_pc=0, stall_frontend=0, busy=0.
- Latency: a request accepted in cycle t produces flush_* and redirect_valid in cycle t+1, both for exactly one cycle. The outputs are registered, with no combinational path from inputs.
- stall_frontend is high for cycles t+1 .. t+1+RECOVER_CYCLES inclusive.
- redirect_pc holds its value until the next accept.
- Back-to-back accepts: a valid re-accept in cycle t+1 (the FLUSH cycle) yields a second pulse in t+2. The stall window is extended from the new pulse.
- Head wrap: age compare must be correct when pending_idx < rob_head_idx numerically. Example: head=62, idx 1 has age 3.
- If rst_n is deasserted mid-FLUSH or mid-RECOVER, all state and outputs clear immediately. The block is in IDLE at the first clock edge after rst_n rises.

## Test plan
- Single mispredict: head=0; port1 br_valid=1, mispredict=1, idx=5, target=0x8000_0100 at cycle 10. Required: flush_* (not cp0) and redirect_pc=0x8000_0100 high in cycle 11 only; stall_frontend high in cycles 11-13 (RECOVER_CYCLES=2); busy=0 in cycle 14.
- Oldest-wins with wrap: head=60; port0 idx=2 (age 6), port1 idx=62 (age 2), same cycle. Required: redirect to the port1 target. Repeat with equal idx on both ports: port0 wins.
- Exception priority: except_valid with vector 0xBFC0_0380 plus a port0 mispredict in the same cycle. Required: redirect_pc=0xBFC0_0380, flush_cp0=1 in the next cycle.
- Recovery filtering: after a flush on idx=10 (head=4), in RECOVER a mispredict at idx=20 is dropped (no pulse). Then a mispredict at idx=7 is accepted: a second pulse one cycle later, and stall extended by RECOVER_CYCLES from that pulse.
- RECOVER_CYCLES=0 build: single mispredict. Required: stall_frontend and busy high for exactly one cycle.
- Reset mid-RECOVER: assert rst_n=0 asynchronously. Required: all outputs 0 before the next clock edge; a new request after release behaves as from IDLE.

Source files
------------

// File: rtl/flush_ctrl.sv
// Pipeline flush/redirect controller: picks the oldest flush cause (exception first),
// emits a one-cycle flush pulse plus redirect PC, then stalls the front end while recovering.
module flush_ctrl #(
  parameter int BRANCH_PORTS   = 2,
  parameter int ROB_IDX_WIDTH  = 6,
  parameter int ADDR_WIDTH     = 32,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  except_valid,
  input  logic [ADDR_WIDTH-1:0]                 except_vector,
  input  logic [ROB_IDX_WIDTH-1:0]              except_rob_idx,
  input  logic [BRANCH_PORTS-1:0]               br_valid,
  input  logic [BRANCH_PORTS-1:0]               br_mispredict,
  input  logic [BRANCH_PORTS*ROB_IDX_WIDTH-1:0] br_rob_idx,
  input  logic [BRANCH_PORTS*ADDR_WIDTH-1:0]    br_target,
  input  logic [ROB_IDX_WIDTH-1:0]              rob_head_idx,
  output logic                                  flush_if,
  output logic                                  flush_is,
  output logic                                  flush_ex,
  output logic                                  flush_rob,
  output logic                                  flush_regstat,
  output logic                                  flush_cp0,
  output logic                                  redirect_valid,
  output logic [ADDR_WIDTH-1:0]                 redirect_pc,
  output logic                                  stall_frontend,
  output logic                                  busy
);

  localparam logic [3:0] RC = 4'(RECOVER_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_RECOVER
  } state_e;

  state_e                   state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [ROB_IDX_WIDTH-1:0] pending_idx_q, pending_idx_d;
  logic                     pending_is_exc_q, pending_is_exc_d;
  logic [ADDR_WIDTH-1:0]    redirect_pc_q, redirect_pc_d;

  logic                     br_found;
  logic [ROB_IDX_WIDTH-1:0] br_age;
  logic [ROB_IDX_WIDTH-1:0] br_idx;
  logic [ADDR_WIDTH-1:0]    br_pc;
  logic [ROB_IDX_WIDTH-1:0] cand_age;
  logic [ROB_IDX_WIDTH-1:0] pend_age;
  logic                     accept_br;

  // Oldest mispredicting branch; strict '<' keeps the lowest port on equal age.
  always_comb begin
    br_found = 1'b0;
    br_age   = '0;
    br_idx   = '0;
    br_pc    = '0;
    cand_age = '0;
    for (int unsigned p = 0; p < BRANCH_PORTS; p++) begin
      cand_age = br_rob_idx[p*ROB_IDX_WIDTH +: ROB_IDX_WIDTH] - rob_head_idx;
      if (br_valid[p] && br_mispredict[p] && (!br_found || cand_age < br_age)) begin
        br_found = 1'b1;
        br_age   = cand_age;
        br_idx   = br_rob_idx[p*ROB_IDX_WIDTH +: ROB_IDX_WIDTH];
        br_pc    = br_target[p*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign pend_age  = pending_idx_q - rob_head_idx;
  assign accept_br = br_found && ((state_q == ST_IDLE) || (br_age < pend_age));

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    pending_idx_d    = pending_idx_q;
    pending_is_exc_d = pending_is_exc_q;
    redirect_pc_d    = redirect_pc_q;

    case (state_q)
      ST_FLUSH: begin
        if (RC == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RECOVER;
          cnt_d   = RC;
        end
      end
      ST_RECOVER: begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: ;
    endcase

    // An accepted cause overrides the window bookkeeping above and restarts it.
    if (except_valid) begin
      state_d          = ST_FLUSH;
      pending_idx_d    = except_rob_idx;
      pending_is_exc_d = 1'b1;
      redirect_pc_d    = except_vector;
    end else if (accept_br) begin
      state_d          = ST_FLUSH;
      pending_idx_d    = br_idx;
      pending_is_exc_d = 1'b0;
      redirect_pc_d    = br_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      pending_idx_q    <= '0;
      pending_is_exc_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      pending_idx_q    <= pending_idx_d;
      pending_is_exc_q <= pending_is_exc_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign flush_if       = (state_q == ST_FLUSH);
  assign flush_is       = (state_q == ST_FLUSH);
  assign flush_ex       = (state_q == ST_FLUSH);
  assign flush_rob      = (state_q == ST_FLUSH);
  assign flush_regstat  = (state_q == ST_FLUSH);
  assign flush_cp0      = (state_q == ST_FLUSH) && pending_is_exc_q;
  assign redirect_valid = (state_q == ST_FLUSH);
  assign redirect_pc    = redirect_pc_q;
  assign stall_frontend = (state_q != ST_IDLE);
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_flush_ctrl.sv
// Bench for flush_ctrl: RECOVER_CYCLES=2 and =0 instances share stimulus and are
// checked every cycle against a cycle-count reference model.
module tb_flush_ctrl;
  localparam int BP = 2;
  localparam int W  = 6;
  localparam int A  = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            except_valid;
  logic [A-1:0]    except_vector;
  logic [W-1:0]    except_rob_idx;
  logic [BP-1:0]   br_valid;
  logic [BP-1:0]   br_mispredict;
  logic [BP*W-1:0] br_rob_idx;
  logic [BP*A-1:0] br_target;
  logic [W-1:0]    rob_head_idx;

  logic fi_a, fs_a, fe_a, fr_a, frs_a, fc_a, rv_a, st_a, bz_a;
  logic fi_b, fs_b, fe_b, fr_b, frs_b, fc_b, rv_b, st_b, bz_b;
  logic [A-1:0] pc_a, pc_b;

  flush_ctrl #(.BRANCH_PORTS(BP), .ROB_IDX_WIDTH(W), .ADDR_WIDTH(A), .RECOVER_CYCLES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .except_valid(except_valid), .except_vector(except_vector),
    .except_rob_idx(except_rob_idx), .br_valid(br_valid), .br_mispredict(br_mispredict),
    .br_rob_idx(br_rob_idx), .br_target(br_target), .rob_head_idx(rob_head_idx),
    .flush_if(fi_a), .flush_is(fs_a), .flush_ex(fe_a), .flush_rob(fr_a), .flush_regstat(frs_a),
    .flush_cp0(fc_a), .redirect_valid(rv_a), .redirect_pc(pc_a), .stall_frontend(st_a), .busy(bz_a));

  flush_ctrl #(.BRANCH_PORTS(BP), .ROB_IDX_WIDTH(W), .ADDR_WIDTH(A), .RECOVER_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .except_valid(except_valid), .except_vector(except_vector),
    .except_rob_idx(except_rob_idx), .br_valid(br_valid), .br_mispredict(br_mispredict),
    .br_rob_idx(br_rob_idx), .br_target(br_target), .rob_head_idx(rob_head_idx),
    .flush_if(fi_b), .flush_is(fs_b), .flush_ex(fe_b), .flush_rob(fr_b), .flush_regstat(frs_b),
    .flush_cp0(fc_b), .redirect_valid(rv_b), .redirect_pc(pc_b), .stall_frontend(st_b), .busy(bz_b));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: stall cycles remaining (including current), pulse this cycle, pending cause.
  int           rcs     [2] = '{2, 0};
  int           m_stall [2];
  bit           m_flush [2];
  bit           m_exc   [2];
  int           m_pend  [2];
  logic [A-1:0] m_pc    [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_stall[d] = 0; m_flush[d] = 0; m_exc[d] = 0; m_pend[d] = 0; m_pc[d] = '0;
    end
  endtask

  function automatic logic [8:0] exp_vec(input int d);
    logic f, s;
    f = m_flush[d];
    s = (m_stall[d] > 0);
    return {f, f, f, f, f, f & m_exc[d], f, s, s};
  endfunction

  task automatic check_outputs();
    chk("ctl_rc2", 32'({fi_a, fs_a, fe_a, fr_a, frs_a, fc_a, rv_a, st_a, bz_a}), 32'(exp_vec(0)));
    chk("pc_rc2", pc_a, m_pc[0]);
    chk("ctl_rc0", 32'({fi_b, fs_b, fe_b, fr_b, frs_b, fc_b, rv_b, st_b, bz_b}), 32'(exp_vec(1)));
    chk("pc_rc0", pc_b, m_pc[1]);
  endtask

  function automatic int age(input int idx);
    return (idx - int'(rob_head_idx) + 64) % 64;
  endfunction

  task automatic model_update();
    int best, bage, idx, a;
    bit acc, exc;
    logic [A-1:0] pc;
    for (int d = 0; d < 2; d++) begin
      acc = 0; exc = 0; idx = 0; pc = '0;
      if (except_valid) begin
        acc = 1; exc = 1; idx = int'(except_rob_idx); pc = except_vector;
      end else begin
        best = -1; bage = 64;
        for (int p = 0; p < BP; p++) begin
          if (br_valid[p] && br_mispredict[p]) begin
            a = age(int'(br_rob_idx[p*W +: W]));
            if (a < bage) begin best = p; bage = a; end
          end
        end
        if (best >= 0 && (m_stall[d] == 0 || bage < age(m_pend[d]))) begin
          acc = 1; idx = int'(br_rob_idx[best*W +: W]); pc = br_target[best*A +: A];
        end
      end
      if (acc) begin
        m_flush[d] = 1; m_stall[d] = 1 + rcs[d]; m_pend[d] = idx; m_exc[d] = exc; m_pc[d] = pc;
      end else begin
        m_flush[d] = 0;
        if (m_stall[d] > 0) m_stall[d]--;
      end
    end
  endtask

  task automatic cycle();
    check_outputs();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_in();
    except_valid = 0; except_vector = '0; except_rob_idx = '0;
    br_valid = '0; br_mispredict = '0; br_rob_idx = '0; br_target = '0;
  endtask

  task automatic set_br(input int p, input int idx, input logic [A-1:0] tgt);
    br_valid[p] = 1'b1;
    br_mispredict[p] = 1'b1;
    br_rob_idx[p*W +: W] = W'(idx);
    br_target[p*A +: A] = tgt;
  endtask

  initial begin
    clear_in();
    rob_head_idx = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    repeat (3) cycle();

    // Single mispredict on port 1
    set_br(1, 5, 32'h8000_0100);
    cycle();
    clear_in();
    chk("tp1_pc", pc_a, 32'h8000_0100);
    chk("tp1_cp0", 32'(fc_a), 32'd0);
    chk("tp1_rc0_busy", 32'(bz_b), 32'd1);
    repeat (3) cycle();
    chk("tp1_idle", 32'(bz_a), 32'd0);
    chk("tp1_rc0_idle", 32'(bz_b), 32'd0);
    cycle();

    // Oldest wins across head wrap, then equal-age tie to port 0
    rob_head_idx = 6'd60;
    set_br(0, 2, 32'h0000_1000);
    set_br(1, 62, 32'h0000_2000);
    cycle();
    clear_in();
    chk("tp2_wrap_pc", pc_a, 32'h0000_2000);
    repeat (4) cycle();
    set_br(0, 10, 32'h0000_3000);
    set_br(1, 10, 32'h0000_4000);
    cycle();
    clear_in();
    chk("tp2_tie_pc", pc_a, 32'h0000_3000);
    repeat (4) cycle();

    // Exception beats a same-cycle branch
    except_valid = 1; except_vector = 32'hBFC0_0380; except_rob_idx = 6'd40;
    set_br(0, 61, 32'h0000_5000);
    cycle();
    clear_in();
    chk("tp3_pc", pc_a, 32'hBFC0_0380);
    chk("tp3_cp0", 32'(fc_a), 32'd1);
    repeat (4) cycle();

    // Recovery filtering with head=4
    rob_head_idx = 6'd4;
    set_br(0, 10, 32'h0000_6000);
    cycle();
    clear_in();
    cycle();
    set_br(0, 20, 32'h0000_7000);
    cycle();
    clear_in();
    chk("tp4_stale_drop", 32'(fi_a), 32'd0);
    set_br(1, 7, 32'h0000_8000);
    cycle();
    clear_in();
    chk("tp4_older_pulse", 32'(fi_a), 32'd1);
    chk("tp4_older_pc", pc_a, 32'h0000_8000);
    repeat (5) cycle();

    // Back-to-back: older branch during the FLUSH cycle
    set_br(0, 30, 32'h0000_9000);
    cycle();
    clear_in();
    set_br(1, 12, 32'h0000_A000);
    cycle();
    clear_in();
    repeat (5) cycle();

    // Asynchronous reset mid-RECOVER
    rob_head_idx = '0;
    set_br(0, 3, 32'h0000_B000);
    cycle();
    clear_in();
    cycle();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_async_ctl", 32'({fi_a, fc_a, rv_a, st_a, bz_a}), 32'd0);
    chk("rst_async_pc", pc_a, 32'd0);
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    set_br(1, 9, 32'h0000_C000);
    cycle();
    clear_in();
    chk("rst_reaccept_pc", pc_a, 32'h0000_C000);
    repeat (4) cycle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      clear_in();
      if ($urandom_range(7) == 0) rob_head_idx = W'($urandom);
      if ($urandom_range(15) == 0) begin
        except_valid = 1; except_vector = $urandom; except_rob_idx = W'($urandom);
      end
      for (int p = 0; p < BP; p++) begin
        br_valid[p] = ($urandom_range(3) == 0);
        br_mispredict[p] = ($urandom_range(1) == 0);
        br_rob_idx[p*W +: W] = W'($urandom);
        br_target[p*A +: A] = $urandom;
      end
      if ($urandom_range(7) == 0) br_rob_idx[W +: W] = br_rob_idx[0 +: W];
      cycle();
    end
    clear_in();
    repeat (4) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
